// File: rtl/maxpool_scan.sv
// Max-pooling window sequencer: drives row/column picks one element per clock,
// keeps a running max and writes each window result into a flattened map.
// Optional build macro MAXPOOL_SIGNED_EN selects a two's-complement compare.
//
// state | meaning
// IDLE  | waiting for start, indices parked at 0
// SCAN  | walking kernel elements of every output window
// DONE  | one-cycle completion pulse, data_o valid
module maxpool_scan #(
  parameter int datai_width   = 4,
  parameter int datai_height  = 4,
  parameter int kernel_width  = 2,
  parameter int kernel_height = 2,
  parameter int stride        = 2,
  parameter int padding       = 0,
  parameter int datao_width   = ((datai_width - kernel_width + 2*padding) / stride) + 1,
  parameter int datao_height  = ((datai_height - kernel_height + 2*padding) / stride) + 1,
  parameter int bitwidth      = 3
) (
  input  logic                                           clk_en,
  input  logic                                           reset_n,
  input  logic                                           start,
  output logic                                           pool_on,
  output logic [3:0]                                     data_l,
  output logic [3:0]                                     data_c,
  input  logic [bitwidth-1:0]                            data_pick,
  output logic [datao_width*datao_height*bitwidth-1:0]   data_o,
  output logic                                           busy,
  output logic                                           done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int         NSLOT   = datao_width * datao_height;
  localparam logic [3:0] KW_LAST = 4'(kernel_width - 1);
  localparam logic [3:0] KH_LAST = 4'(kernel_height - 1);
  localparam logic [3:0] OW_LAST = 4'(datao_width - 1);
  localparam logic [3:0] OH_LAST = 4'(datao_height - 1);
  localparam logic [3:0] STRIDE4 = 4'(stride);

  logic [1:0]          state;
  logic [3:0]          orow, ocol, kr, kc;
  logic [bitwidth-1:0] maxr, cur_max;
  logic                first_elem, last_elem, pick_gt;
  logic [7:0]          slot;

  always_comb begin
    first_elem = (kr == 4'd0) && (kc == 4'd0);
    last_elem  = (kr == KH_LAST) && (kc == KW_LAST);
`ifdef MAXPOOL_SIGNED_EN
    pick_gt    = $signed(data_pick) > $signed(maxr);
`else
    pick_gt    = data_pick > maxr;
`endif
    // The first element of a window loads unconditionally, never compared against stale maxr.
    cur_max    = (first_elem || pick_gt) ? data_pick : maxr;
    slot       = 8'(orow) * 8'(datao_width) + 8'(ocol);
  end

  assign pool_on = (state == SCAN);
  assign busy    = (state == SCAN) || (state == DONE);
  assign done    = (state == DONE);
  assign data_l  = pool_on ? (orow * STRIDE4 + kr) : 4'd0;
  assign data_c  = pool_on ? (ocol * STRIDE4 + kc) : 4'd0;

  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      state  <= IDLE;
      orow   <= '0;
      ocol   <= '0;
      kr     <= '0;
      kc     <= '0;
      maxr   <= '0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            orow  <= '0;
            ocol  <= '0;
            kr    <= '0;
            kc    <= '0;
          end
        end
        SCAN: begin
          maxr <= cur_max;
          for (int s = 0; s < NSLOT; s++) begin
            if (last_elem && (slot == 8'(s)))
              data_o[s*bitwidth +: bitwidth] <= cur_max;
          end
          if (kc == KW_LAST) begin
            kc <= '0;
            if (kr == KH_LAST) begin
              kr <= '0;
              if (ocol == OW_LAST) begin
                ocol <= '0;
                if (orow == OH_LAST) begin
                  orow  <= '0;
                  state <= DONE;
                end else begin
                  orow <= orow + 4'd1;
                end
              end else begin
                ocol <= ocol + 4'd1;
              end
            end else begin
              kr <= kr + 4'd1;
            end
          end else begin
            kc <= kc + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
